// File: rtl/pe_array_controller.sv
// ============================================================================
// pe_array_controller
// ----------------------------------------------------------------------------
// Control FSM that sits directly upstream of the 3-PE convolution datapath.
// For each job it:
//   1. preloads the filters into every PE (filter address generator),
//   2. loads one ifmap row into each PE in turn (ifmap address generator),
//   3. fires start_PE and waits for the PEs to report ready again,
//   4. repeats steps 2-3 for the configured number of passes.
// Filters stay resident across passes, so LOAD_FILT runs once per job.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   start             : one-cycle job request, only honoured in IDLE
//   cfg_num_passes    : passes per job (0 is treated as 1)
//   cfg_mode/filt_len/stride_len : PE configuration, captured on start
//   co_onehot         : filter one-hot rotation complete (all filters written)
//   co_ifG            : ifmap address counter carry-out (one PE row loaded)
//   done_all          : level, all PEs ready_to_get
//   sel_addr_SRAM     : 1 = ifmap address generator, 0 = filter generator
//   filter_cnt_en     : filter address counter enable
//   ifg_cnt_en        : ifmap address counter enable
//   ifmap_wen         : one-hot ifmap write enable, bit k = PE k
//   start_PE          : one-cycle PE start pulse
//   mode/filt_len/stride_len : registered configuration for the whole job
//   pass_idx          : current pass, 0-based; holds after the job ends
//   busy              : high in every state except IDLE and FIN
//   done              : one-cycle job-complete pulse
//
// Every output is a register. The output values are decoded from the
// *next* state, so they line up cycle-for-cycle with the state they belong
// to, without any combinational path from inputs to outputs.
// ============================================================================
module pe_array_controller #(
    parameter int NUM_PE = 3,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PASS_W-1:0] cfg_num_passes,
    input  logic              cfg_mode,
    input  logic              cfg_filt_len,
    input  logic              cfg_stride_len,
    input  logic              co_onehot,
    input  logic              co_ifG,
    input  logic              done_all,
    output logic              sel_addr_SRAM,
    output logic              filter_cnt_en,
    output logic              ifg_cnt_en,
    output logic [NUM_PE-1:0] ifmap_wen,
    output logic              start_PE,
    output logic              mode,
    output logic              filt_len,
    output logic              stride_len,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done
);

    localparam int PE_SEL_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [PE_SEL_W-1:0] LAST_PE  = PE_SEL_W'(NUM_PE - 1);
    localparam logic [PASS_W-1:0]   ONE_PASS = PASS_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_FILT = 3'd1,
        S_LOAD_IF   = 3'd2,
        S_START     = 3'd3,
        S_WAIT_LOW  = 3'd4,
        S_WAIT_HIGH = 3'd5,
        S_NEXT      = 3'd6,
        S_FIN       = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              state_reg,      state_next;
    logic [PE_SEL_W-1:0] pe_sel_reg,     pe_sel_next;
    logic [PASS_W-1:0]   pass_idx_reg,   pass_idx_next;
    logic [PASS_W-1:0]   num_passes_reg, num_passes_next;
    logic                mode_reg,       mode_next;
    logic                filt_len_reg,   filt_len_next;
    logic                stride_len_reg, stride_len_next;

    // Registered outputs
    logic                sel_addr_reg,   sel_addr_next;
    logic                filt_en_reg,    filt_en_next;
    logic                ifg_en_reg,     ifg_en_next;
    logic [NUM_PE-1:0]   ifmap_wen_reg,  ifmap_wen_next;
    logic                start_pe_reg,   start_pe_next;
    logic                busy_reg,       busy_next;
    logic                done_reg,       done_next;

    // ------------------------------------------------------------------
    // Sequential process
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            pe_sel_reg     <= '0;
            pass_idx_reg   <= '0;
            num_passes_reg <= '0;
            mode_reg       <= 1'b0;
            filt_len_reg   <= 1'b0;
            stride_len_reg <= 1'b0;
            sel_addr_reg   <= 1'b0;
            filt_en_reg    <= 1'b0;
            ifg_en_reg     <= 1'b0;
            ifmap_wen_reg  <= '0;
            start_pe_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pe_sel_reg     <= pe_sel_next;
            pass_idx_reg   <= pass_idx_next;
            num_passes_reg <= num_passes_next;
            mode_reg       <= mode_next;
            filt_len_reg   <= filt_len_next;
            stride_len_reg <= stride_len_next;
            sel_addr_reg   <= sel_addr_next;
            filt_en_reg    <= filt_en_next;
            ifg_en_reg     <= ifg_en_next;
            ifmap_wen_reg  <= ifmap_wen_next;
            start_pe_reg   <= start_pe_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        pe_sel_next     = pe_sel_reg;
        pass_idx_next   = pass_idx_reg;
        num_passes_next = num_passes_reg;
        mode_next       = mode_reg;
        filt_len_next   = filt_len_reg;
        stride_len_next = stride_len_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    mode_next       = cfg_mode;
                    filt_len_next   = cfg_filt_len;
                    stride_len_next = cfg_stride_len;
                    // A zero pass count would otherwise wrap the
                    // last-pass compare and run 2^PASS_W passes.
                    num_passes_next = (cfg_num_passes == '0) ? ONE_PASS
                                                              : cfg_num_passes;
                    pass_idx_next   = '0;
                    pe_sel_next     = '0;
                    state_next      = S_LOAD_FILT;
                end
            end

            S_LOAD_FILT: begin
                if (co_onehot) begin
                    pe_sel_next = '0;
                    state_next  = S_LOAD_IF;
                end
            end

            S_LOAD_IF: begin
                // The carry-out cycle still writes the current PE; the
                // next PE (or START) follows with no idle cycle between.
                if (co_ifG) begin
                    if (pe_sel_reg == LAST_PE) begin
                        state_next = S_START;
                    end else begin
                        pe_sel_next = pe_sel_reg + 1'b1;
                    end
                end
            end

            S_START: begin
                state_next = S_WAIT_LOW;
            end

            // done_all may still be high from the previous pass (or from
            // power-up). Seeing it fall first guarantees the high level we
            // act on in WAIT_HIGH belongs to the pass just started.
            S_WAIT_LOW: begin
                if (!done_all) begin
                    state_next = S_WAIT_HIGH;
                end
            end

            S_WAIT_HIGH: begin
                if (done_all) begin
                    state_next = S_NEXT;
                end
            end

            S_NEXT: begin
                if (pass_idx_reg == (num_passes_reg - ONE_PASS)) begin
                    state_next = S_FIN;
                end else begin
                    // Filters are still resident in the PEs; only the
                    // ifmap rows are reloaded for the next pass.
                    pass_idx_next = pass_idx_reg + ONE_PASS;
                    pe_sel_next   = '0;
                    state_next    = S_LOAD_IF;
                end
            end

            S_FIN: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state (registered above, so outputs are
    // a pure function of the current state once they reach the ports).
    // ------------------------------------------------------------------
    always_comb begin
        sel_addr_next = 1'b0;
        filt_en_next  = 1'b0;
        ifg_en_next   = 1'b0;
        start_pe_next = 1'b0;
        done_next     = 1'b0;

        case (state_next)
            S_LOAD_FILT: begin
                filt_en_next = 1'b1;
            end
            S_LOAD_IF: begin
                sel_addr_next = 1'b1;
                ifg_en_next   = 1'b1;
            end
            S_START: begin
                start_pe_next = 1'b1;
            end
            S_FIN: begin
                done_next = 1'b1;
            end
            default: begin
            end
        endcase

        busy_next = (state_next != S_IDLE) && (state_next != S_FIN);
    end

    // One write-enable bit per PE. Only the selected PE is written, and only
    // while ifmap rows are being loaded, so the vector is one-hot or zero.
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_wen
        assign ifmap_wen_next[gi] = (state_next == S_LOAD_IF) &&
                                    (pe_sel_next == PE_SEL_W'(gi));
    end

    // ------------------------------------------------------------------
    // Port assignments
    // ------------------------------------------------------------------
    assign sel_addr_SRAM = sel_addr_reg;
    assign filter_cnt_en = filt_en_reg;
    assign ifg_cnt_en    = ifg_en_reg;
    assign ifmap_wen     = ifmap_wen_reg;
    assign start_PE      = start_pe_reg;
    assign mode          = mode_reg;
    assign filt_len      = filt_len_reg;
    assign stride_len    = stride_len_reg;
    assign pass_idx      = pass_idx_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_pe_array_controller.sv
// ============================================================================
// tb_pe_array_controller
// ----------------------------------------------------------------------------
// Bench for pe_array_controller. A small datapath model answers the
// controller: co_onehot after FILT_LEN filter cycles, co_ifG every IF_LEN
// ifmap cycles, and done_all dropping/rising after each start_PE.
// Expected ifmap_wen values and pass indices are queued when a job is
// launched and popped as the controller produces them.
// ============================================================================
module tb_pe_array_controller;

    localparam int NUM_PE   = 3;
    localparam int PASS_W   = 8;
    localparam int FILT_LEN = 9;
    localparam int IF_LEN   = 4;
    localparam int BUDGET   = 800;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [PASS_W-1:0] cfg_num_passes = '0;
    logic              cfg_mode = 1'b0;
    logic              cfg_filt_len = 1'b0;
    logic              cfg_stride_len = 1'b0;
    logic              co_onehot = 1'b0;
    logic              co_ifG = 1'b0;
    logic              done_all = 1'b0;
    logic              sel_addr_SRAM;
    logic              filter_cnt_en;
    logic              ifg_cnt_en;
    logic [NUM_PE-1:0] ifmap_wen;
    logic              start_PE;
    logic              mode;
    logic              filt_len;
    logic              stride_len;
    logic [PASS_W-1:0] pass_idx;
    logic              busy;
    logic              done;

    logic [19:0]       all_outs;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [NUM_PE-1:0] wen_q[$];
    logic [PASS_W-1:0] pidx_q[$];

    pe_array_controller #(
        .NUM_PE (NUM_PE),
        .PASS_W (PASS_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_num_passes (cfg_num_passes),
        .cfg_mode       (cfg_mode),
        .cfg_filt_len   (cfg_filt_len),
        .cfg_stride_len (cfg_stride_len),
        .co_onehot      (co_onehot),
        .co_ifG         (co_ifG),
        .done_all       (done_all),
        .sel_addr_SRAM  (sel_addr_SRAM),
        .filter_cnt_en  (filter_cnt_en),
        .ifg_cnt_en     (ifg_cnt_en),
        .ifmap_wen      (ifmap_wen),
        .start_PE       (start_PE),
        .mode           (mode),
        .filt_len       (filt_len),
        .stride_len     (stride_len),
        .pass_idx       (pass_idx),
        .busy           (busy),
        .done           (done)
    );

    assign all_outs = {sel_addr_SRAM, filter_cnt_en, ifg_cnt_en, ifmap_wen,
                       start_PE, mode, filt_len, stride_len, pass_idx,
                       busy, done};

    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Runs one job from IDLE: launches start, plays the datapath, and checks
    // every cycle until done (or the cycle budget runs out).
    // ------------------------------------------------------------------
    task automatic run_job(input int passes, input bit m, input bit fl, input bit sl,
                           input bit stale, input bit poke, input bit fin_start,
                           input bit abort_wh, input string name);
        int eff;
        int filt_cnt;
        int if_cnt;
        int starts;
        int filt_entries;
        int if_entries;
        int pe_at;
        int rise_at;
        int d;
        int cycles;
        bit prev_filt;
        bit prev_if;
        bit finished;
        bit exp_done;
        bit last;
        logic [PASS_W-1:0] exp_pidx;
        logic [NUM_PE-1:0] exp_wen;
        logic [PASS_W-1:0] exp_p;

        eff = (passes == 0) ? 1 : passes;
        filt_cnt = 0; if_cnt = 0; starts = 0; filt_entries = 0; if_entries = 0;
        pe_at = -1; rise_at = -1; cycles = 0;
        prev_filt = 1'b0; prev_if = 1'b0; finished = 1'b0;
        exp_pidx = '0;

        wen_q.delete();
        pidx_q.delete();
        for (int p = 0; p < eff; p++) begin
            pidx_q.push_back(PASS_W'(p));
            for (int pe = 0; pe < NUM_PE; pe++) begin
                for (int k = 0; k < IF_LEN; k++) begin
                    wen_q.push_back(NUM_PE'(1) << pe);
                end
            end
        end

        cfg_num_passes = PASS_W'(passes);
        cfg_mode       = m;
        cfg_filt_len   = fl;
        cfg_stride_len = sl;
        start          = 1'b1;

        for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            tick();
            cycles = cyc + 1;
            start          = 1'b0;
            co_onehot      = 1'b0;
            co_ifG         = 1'b0;
            cfg_mode       = ~m;
            cfg_filt_len   = ~fl;
            cfg_stride_len = ~sl;
            cfg_num_passes = PASS_W'(passes + 1);

            if (cyc == 0) begin
                vec_cnt++;
                if ({busy, filter_cnt_en, sel_addr_SRAM, ifg_cnt_en} !== 4'b1100) begin
                    err_cnt++;
                    $display("FAIL %s/first_cycle: got busy,fen,sel,ien=%b expected 1100", name,
                             {busy, filter_cnt_en, sel_addr_SRAM, ifg_cnt_en});
                end
            end

            vec_cnt++;
            if ({mode, filt_len, stride_len} !== {m, fl, sl}) begin
                err_cnt++;
                $display("FAIL %s/config: cyc %0d got %b expected %b", name, cyc,
                         {mode, filt_len, stride_len}, {m, fl, sl});
            end

            vec_cnt++;
            if ((filter_cnt_en & ifg_cnt_en) !== 1'b0) begin
                err_cnt++;
                $display("FAIL %s/en_excl: cyc %0d got both enables high expected at most one", name, cyc);
            end

            if (!ifg_cnt_en) begin
                vec_cnt++;
                if (ifmap_wen !== '0) begin
                    err_cnt++;
                    $display("FAIL %s/wen_idle: cyc %0d got %b expected 000", name, cyc, ifmap_wen);
                end
            end

            last     = (starts == eff);
            exp_done = (rise_at >= 0) && (cyc == rise_at + 2) && last;

            if ((rise_at >= 0) && (cyc == rise_at + 2) && !last) begin
                exp_pidx = PASS_W'(starts);
                vec_cnt++;
                if ({ifg_cnt_en, filter_cnt_en} !== 2'b10) begin
                    err_cnt++;
                    $display("FAIL %s/next_pass: cyc %0d got ien,fen=%b expected 10", name, cyc,
                             {ifg_cnt_en, filter_cnt_en});
                end
            end

            vec_cnt++;
            if (done !== exp_done) begin
                err_cnt++;
                $display("FAIL %s/done: cyc %0d got %b expected %b", name, cyc, done, exp_done);
            end
            vec_cnt++;
            if (busy !== !exp_done) begin
                err_cnt++;
                $display("FAIL %s/busy: cyc %0d got %b expected %b", name, cyc, busy, !exp_done);
            end
            vec_cnt++;
            if (pass_idx !== exp_pidx) begin
                err_cnt++;
                $display("FAIL %s/pass_idx: cyc %0d got %0d expected %0d", name, cyc, pass_idx, exp_pidx);
            end

            if (filter_cnt_en) begin
                vec_cnt++;
                if (sel_addr_SRAM !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL %s/sel_filt: cyc %0d got %b expected 0", name, cyc, sel_addr_SRAM);
                end
                if (!prev_filt) filt_entries++;
                filt_cnt++;
                if (filt_cnt == FILT_LEN) co_onehot = 1'b1;
            end

            if (ifg_cnt_en) begin
                vec_cnt++;
                if (sel_addr_SRAM !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL %s/sel_if: cyc %0d got %b expected 1", name, cyc, sel_addr_SRAM);
                end
                if (!prev_if) if_entries++;
                vec_cnt++;
                if (wen_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL %s/wen_extra: cyc %0d got %b expected no write", name, cyc, ifmap_wen);
                end else begin
                    exp_wen = wen_q.pop_front();
                    if (ifmap_wen !== exp_wen) begin
                        err_cnt++;
                        $display("FAIL %s/wen: cyc %0d got %b expected %b", name, cyc, ifmap_wen, exp_wen);
                    end
                end
                if_cnt++;
                if ((if_cnt % IF_LEN) == 0) co_ifG = 1'b1;
                if (poke && if_cnt == 5) start = 1'b1;
            end

            // Carry-outs outside their own load state must be ignored.
            if (poke) begin
                if (!filter_cnt_en) co_onehot = 1'b1;
                if (!ifg_cnt_en)    co_ifG    = 1'b1;
            end

            prev_filt = filter_cnt_en;
            prev_if   = ifg_cnt_en;

            if (start_PE) begin
                starts++;
                vec_cnt++;
                if (pidx_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL %s/start_pe_extra: cyc %0d got pulse expected none", name, cyc);
                end else begin
                    exp_p = pidx_q.pop_front();
                    if (pass_idx !== exp_p) begin
                        err_cnt++;
                        $display("FAIL %s/start_pe_pass: cyc %0d got %0d expected %0d", name, cyc, pass_idx, exp_p);
                    end
                end
                pe_at   = cyc;
                rise_at = cyc + (stale ? 5 : 3);
            end

            // Datapath model of done_all after each start_PE.
            if (pe_at >= 0) begin
                d = cyc - pe_at;
                if (stale) done_all = (d != 4);
                else       done_all = (d >= 3);
            end

            if (abort_wh && (pe_at >= 0) && (cyc == pe_at + 2)) begin
                #3;
                rst = 1'b1;
                #1;
                vec_cnt++;
                if (all_outs !== '0) begin
                    err_cnt++;
                    $display("FAIL %s/async_rst: got outputs %h expected 0", name, all_outs);
                end
                tick();
                vec_cnt++;
                if (all_outs !== '0) begin
                    err_cnt++;
                    $display("FAIL %s/rst_hold: got outputs %h expected 0", name, all_outs);
                end
                rst = 1'b0;
                co_onehot = 1'b0;
                co_ifG = 1'b0;
                done_all = 1'b0;
                wen_q.delete();
                pidx_q.delete();
                $display("job %s: reset in WAIT_HIGH after %0d cycles", name, cycles);
                return;
            end

            finished = exp_done;
        end

        if (!finished) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s/timeout: got no done in %0d cycles expected done", name, BUDGET);
        end

        // This is the FIN cycle; a start here must be ignored.
        if (fin_start) start = 1'b1;
        tick();
        start = 1'b0;
        co_onehot = 1'b0;
        co_ifG = 1'b0;

        vec_cnt++;
        if ({busy, done, filter_cnt_en, ifg_cnt_en, start_PE} !== 5'b0) begin
            err_cnt++;
            $display("FAIL %s/post_idle: got b,d,fen,ien,spe=%b expected 00000", name,
                     {busy, done, filter_cnt_en, ifg_cnt_en, start_PE});
        end
        vec_cnt++;
        if (pass_idx !== PASS_W'(eff - 1)) begin
            err_cnt++;
            $display("FAIL %s/pass_hold: got %0d expected %0d", name, pass_idx, eff - 1);
        end
        vec_cnt++;
        if ({mode, filt_len, stride_len} !== {m, fl, sl}) begin
            err_cnt++;
            $display("FAIL %s/config_hold: got %b expected %b", name, {mode, filt_len, stride_len}, {m, fl, sl});
        end
        vec_cnt++;
        if (wen_q.size() != 0 || pidx_q.size() != 0) begin
            err_cnt++;
            $display("FAIL %s/leftover: got %0d wen / %0d pass entries unconsumed expected 0", name,
                     wen_q.size(), pidx_q.size());
        end
        vec_cnt++;
        if (filt_entries != 1 || if_entries != eff || starts != eff) begin
            err_cnt++;
            $display("FAIL %s/counts: got filt=%0d if=%0d starts=%0d expected 1/%0d/%0d", name,
                     filt_entries, if_entries, starts, eff, eff);
        end

        $display("job %s: passes=%0d effective=%0d cycles=%0d", name, passes, eff, cycles);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if (all_outs !== '0) begin
            err_cnt++;
            $display("FAIL reset/in_reset: got outputs %h expected 0", all_outs);
        end
        rst = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if (all_outs !== '0) begin
            err_cnt++;
            $display("FAIL reset/idle: got outputs %h expected 0", all_outs);
        end
        $display("job reset: outputs %h", all_outs);
    endtask

    task automatic test_single_pass();
        run_job(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "single_pass");
    endtask

    task automatic test_multi_pass();
        run_job(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "multi_pass");
    endtask

    task automatic test_stale_ready();
        done_all = 1'b1;
        run_job(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "stale_ready");
    endtask

    task automatic test_start_ignored();
        run_job(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "busy_start_np0");
    endtask

    task automatic test_back_to_back();
        run_job(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "fin_start");
        run_job(2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "after_fin");
    endtask

    task automatic test_async_reset();
        run_job(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "abort");
        run_job(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_stale_ready();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
